// File: rtl/rom_port_ctrl.sv
// Sequences word-addressed read requests onto the external boot-ROM pins.
// Writes are rejected; a one-entry last-address cache serves repeated fetches.
module rom_port_ctrl #(
    parameter int ADDR_W     = 14,
    parameter int ROM_ADDR_W = 12,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2,
    parameter int CACHE_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  ROM_enable,
    output logic                  ROM_read,
    output logic [ROM_ADDR_W-1:0] ROM_address,
    input  logic [DATA_W-1:0]     ROM_out
);

    // state  | meaning
    // IDLE   | ready for a request
    // ACCESS | ROM enabled, waiting LATENCY cycles for ROM_out
    // RESP   | response held until rsp_ready
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [3:0]              cnt_q;
    logic [DATA_W-1:0]       rsp_data_q;
    logic                    rsp_err_q;
    logic                    rom_en_q;
    logic [ROM_ADDR_W-1:0]   rom_addr_q;
    logic                    cache_valid_q;
    logic [ADDR_W-1:0]       cache_addr_q;
    logic [DATA_W-1:0]       cache_data_q;
    logic                    cache_hit;
    logic                    last_cycle;

    // Hit compare uses the full request address, so ROM aliases do not hit.
    assign cache_hit  = (CACHE_EN != 0) && cache_valid_q && (req_addr == cache_addr_q);
    assign last_cycle = (cnt_q == 4'(LATENCY - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_write || cache_hit) state_d = RESP;
                    else                        state_d = ACCESS;
                end
            end
            ACCESS:  if (last_cycle) state_d = RESP;
            RESP:    if (rsp_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rom_en_q      <= 1'b0;
            rom_addr_q    <= '0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt_q  <= '0;
                        if (req_write) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end else if (cache_hit) begin
                            rsp_err_q  <= 1'b0;
                            rsp_data_q <= cache_data_q;
                        end else begin
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= req_addr[ROM_ADDR_W-1:0];
                        end
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (last_cycle) begin
                        rsp_data_q    <= ROM_out;
                        rsp_err_q     <= 1'b0;
                        rom_en_q      <= 1'b0;
                        cache_valid_q <= 1'b1;
                        cache_addr_q  <= addr_q;
                        cache_data_q  <= ROM_out;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign ROM_enable  = rom_en_q;
    assign ROM_read    = rom_en_q;
    assign ROM_address = rom_addr_q;

endmodule
